// File: rtl/axis_fs4_mixer_pkg.sv
// -----------------------------------------------------------------------------
// axis_fs4_mixer_pkg
// Shared types and helpers for the fs/4 complex mixer.
//   phase_t   : 2-bit rotation phase n (rotation by (-/+j)^n)
//   cplx_t    : packed complex sample {q, i} at the default 16-bit width
//   sat_neg() : saturating two's-complement negate of a DW-bit value held
//               sign-extended in MAX_DW bits
// -----------------------------------------------------------------------------
package axis_fs4_mixer_pkg;

    localparam int unsigned MAX_DW     = 64;
    localparam int unsigned DEFAULT_DW = 16;

    typedef logic [1:0] phase_t;

    typedef struct packed {
        logic [DEFAULT_DW-1:0] q;
        logic [DEFAULT_DW-1:0] i;
    } cplx_t;

    // The most negative DW-bit value has no positive counterpart, so it maps
    // to the most positive one; every other value negates exactly.
    function automatic logic [MAX_DW-1:0] sat_neg(input logic [MAX_DW-1:0] x,
                                                  input int unsigned      dw);
        logic [MAX_DW-1:0] min_v;
        logic [MAX_DW-1:0] max_v;
        min_v = '1;
        min_v = min_v << (dw - 1);
        max_v = ~min_v;
        return (x == min_v) ? max_v : (~x + MAX_DW'(1));
    endfunction

endpackage

// File: rtl/axis_fs4_mixer_skid.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Single-entry skid buffer with a registered upstream ready. When empty it is
// transparent (downstream sees the upstream beat combinationally); a beat
// accepted while downstream is not ready is parked and upstream ready drops
// on the following edge.
//   clk_i/rst_ni          : clock, asynchronous active-low reset
//   s_data_i/s_valid_i    : upstream payload / valid
//   s_ready_o             : upstream ready (registered)
//   m_data_o/m_valid_o    : downstream payload / valid
//   m_ready_i             : downstream ready
// -----------------------------------------------------------------------------
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic             ready_q,      ready_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (m_ready_i) begin
                skid_valid_d = 1'b0;
            end
        end else if (s_valid_i && ready_q && !m_ready_i) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data_i;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            ready_q      <= ready_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = skid_valid_q || (s_valid_i && ready_q);
    assign m_data_o  = skid_valid_q ? skid_data_q : s_data_i;

endmodule

// File: rtl/axis_fs4_mixer.sv
// -----------------------------------------------------------------------------
// axis_fs4_mixer
// Multiplier-free fs/4 frequency shifter for complex AXI-Stream samples.
// Each accepted beat is rotated by e^(-/+ j*pi*n/2) using swap/saturating
// negate only; n advances on every input handshake and optionally returns
// to 0 after a tlast beat. Output is registered, fully back-pressurable.
//   aclk, aresetn                : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast    : input sample {Q, I}, valid, packet end
//   s_axis_tready                : input ready (registered)
//   m_axis_tdata/tvalid/tlast    : rotated sample, valid, packet end
//   m_axis_tready                : output ready
//   m_axis_tuser [1:0]           : phase used for the beat (only when
//                                  AXIS_FS4_MIXER_TUSER_EN is defined)
// Configuration macro: AXIS_FS4_MIXER_TUSER_EN
// -----------------------------------------------------------------------------
module axis_fs4_mixer
    import axis_fs4_mixer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 16,
    parameter bit          DIRECTION           = 1'b0,
    parameter bit          PHASE_RESET_ON_LAST = 1'b1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
`ifdef AXIS_FS4_MIXER_TUSER_EN
    output logic [1:0]              m_axis_tuser,
`endif
    input  logic                    m_axis_tready
);

    // Skid payload: {phase tag, tlast, sample}. The phase is tagged at the
    // input handshake so a parked beat keeps the rotation it was accepted with.
    localparam int unsigned PW = 2*DATA_WIDTH + 3;

    logic [PW-1:0]           sk_in;
    logic [PW-1:0]           sk_out;
    logic                    sk_valid;
    logic                    sk_ready;
    logic                    s_ready;
    logic                    in_hs;

    phase_t                  phase_q, phase_d;
    phase_t                  sk_phase;
    phase_t                  eff_n;
    logic                    sk_last;
    logic [DATA_WIDTH-1:0]   sk_i, sk_q;
    logic [2*DATA_WIDTH-1:0] rot;

    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q,  m_last_d;
    logic [2*DATA_WIDTH-1:0] m_data_q,  m_data_d;

    function automatic logic [DATA_WIDTH-1:0] neg(input logic [DATA_WIDTH-1:0] v);
        logic [MAX_DW-1:0] r;
        r = sat_neg(MAX_DW'($signed(v)), DATA_WIDTH);
        return r[DATA_WIDTH-1:0];
    endfunction

    // ---------------- input skid + phase counter ----------------
    assign sk_in = {phase_q, s_axis_tlast, s_axis_tdata};
    assign in_hs = s_axis_tvalid && s_ready;

    axis_skid_buffer #(
        .WIDTH (PW)
    ) u_skid (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .s_data_i  (sk_in),
        .s_valid_i (s_axis_tvalid),
        .s_ready_o (s_ready),
        .m_data_o  (sk_out),
        .m_valid_o (sk_valid),
        .m_ready_i (sk_ready)
    );

    assign s_axis_tready = s_ready;

    always_comb begin
        phase_d = phase_q;
        if (in_hs) begin
            if (PHASE_RESET_ON_LAST && s_axis_tlast) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // ---------------- rotation ----------------
    assign sk_phase = sk_out[PW-1 -: 2];
    assign sk_last  = sk_out[2*DATA_WIDTH];
    assign sk_i     = sk_out[DATA_WIDTH-1:0];
    assign sk_q     = sk_out[2*DATA_WIDTH-1:DATA_WIDTH];

    // Upshift is the downshift table with the n=1 and n=3 rows swapped.
    always_comb begin
        eff_n = sk_phase;
        if (DIRECTION && sk_phase[0]) begin
            eff_n = sk_phase ^ 2'b10;
        end
        rot = {sk_q, sk_i};
        unique case (eff_n)
            2'd0: rot = {sk_q, sk_i};
            2'd1: rot = {neg(sk_i), sk_q};
            2'd2: rot = {neg(sk_q), neg(sk_i)};
            2'd3: rot = {sk_i, neg(sk_q)};
        endcase
    end

    // ---------------- output register ----------------
    assign sk_ready = !m_valid_q || m_axis_tready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (sk_ready) begin
            m_valid_d = sk_valid;
            if (sk_valid) begin
                m_data_d = rot;
                m_last_d = sk_last;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;

`ifdef AXIS_FS4_MIXER_TUSER_EN
    phase_t m_user_q, m_user_d;

    always_comb begin
        m_user_d = m_user_q;
        if (sk_ready && sk_valid) begin
            m_user_d = sk_phase;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_user_q <= '0;
        end else begin
            m_user_q <= m_user_d;
        end
    end

    assign m_axis_tuser = m_user_q;
`else
    // Phase tag only steers the rotation; no sideband output storage.
`endif

endmodule
